// File: rtl/prefetch_store_buffer.sv
// Store-buffer responder for the prefetcher: a DEPTH x 32-bit scratch array with
// two independent write ports and a dual-word read that answers after a fixed
// LATENCY. Reads see same-cycle writes (port 1 has priority over port 0).
module prefetch_store_buffer #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_req,
    input  logic [1:0][31:0] r_addr,
    input  logic [1:0]       wren,
    input  logic [1:0][31:0] w_addr,
    input  logic [1:0][31:0] w_data,
    output logic             wait_o,
    output logic             data_ready,
    output logic [1:0][31:0] data_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic             accept;
    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    r_idx [2];
    logic [AW-1:0]    w_idx [2];
    logic [1:0][31:0] rd_p0;
    logic [1:0][31:0] hold_p1;
    logic             unused_addr_bits;

    // Byte offset and bits above the array size are dropped, so addresses alias.
    assign unused_addr_bits = ^{r_addr, w_addr};

    // Write-first read: a word written at the same edge returns the new data,
    // with port 1 overriding port 0 when both hit the same word.
    function automatic logic [31:0] bypass_word(
        input logic [31:0]   stored,
        input logic [AW-1:0] idx,
        input logic [1:0]    we,
        input logic [AW-1:0] wi0,
        input logic [AW-1:0] wi1,
        input logic [31:0]   wd0,
        input logic [31:0]   wd1
    );
        logic [31:0] word;
        word = stored;
        if (we[0] && (wi0 == idx)) word = wd0;
        if (we[1] && (wi1 == idx)) word = wd1;
        return word;
    endfunction

    // Word index decode and bypassed read of both requested words
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            r_idx[i] = r_addr[i][AW+1:2];
            w_idx[i] = w_addr[i][AW+1:2];
        end
        for (int i = 0; i < 2; i++) begin
            rd_p0[i] = bypass_word(mem[r_idx[i]], r_idx[i], wren, w_idx[0], w_idx[1],
                                   w_data[0], w_data[1]);
        end
    end

    // Storage writes happen every cycle regardless of state or reset; port 1 last so it wins
    always_ff @(posedge clk) begin
        if (wren[0]) mem[w_idx[0]] <= w_data[0];
        if (wren[1]) mem[w_idx[1]] <= w_data[1];
    end

    // ---- stage p0 -> p1: capture the requested words at acceptance
    assign accept = data_req && (state != BUSY);

    // Holding registers freeze the response so later writes are not reflected
    always_ff @(posedge clk) begin
        if (accept) hold_p1 <= rd_p0;
    end

    // ---- stage p1 -> output: present the response on RESP entry and hold it afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o <= '0;
        end else if (state_nxt == RESP) begin
            // From BUSY the held words are used; otherwise LATENCY is 1 and the
            // words accepted at this very edge go straight out.
            data_o <= (state == BUSY) ? hold_p1 : rd_p0;
        end
    end

    // State and latency counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE/RESP, count down in BUSY
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (data_req) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs decode the registered state only; no path from data_req
    always_comb begin
        wait_o     = (state == BUSY);
        data_ready = (state == RESP);
        state_o    = state;
    end

endmodule

// File: tb/tb_prefetch_store_buffer.sv
// Bench for prefetch_store_buffer: four instances with LATENCY 1..4 share one
// stimulus stream and are compared every cycle against a cycle-numbered model.
module tb_prefetch_store_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NDUT  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             data_req;
    logic [1:0][31:0] r_addr;
    logic [1:0]       wren;
    logic [1:0][31:0] w_addr;
    logic [1:0][31:0] w_data;

    logic             wait_v  [NDUT];
    logic             ready_v [NDUT];
    logic [1:0]       st_v    [NDUT];
    logic [1:0][31:0] do_v    [NDUT];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            prefetch_store_buffer #(
                .DEPTH(DEPTH), .AW(AW), .LATENCY(g + 1)
            ) dut (
                .clk(clk), .reset(reset), .data_req(data_req), .r_addr(r_addr),
                .wren(wren), .w_addr(w_addr), .w_data(w_data),
                .wait_o(wait_v[g]), .data_ready(ready_v[g]), .data_o(do_v[g]),
                .state_o(st_v[g])
            );
        end
    endgenerate

    // Reference model: memory contents plus, per instance, the edge number at
    // which its pending response becomes visible.
    logic [31:0] mmem [DEPTH];
    bit          pend [NDUT];
    int          resp [NDUT];
    logic [31:0] pd   [NDUT][2];
    logic [31:0] od   [NDUT][2];
    int          ecyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_edge();
        logic [31:0] cap [2];
        ecyc++;
        for (int i = 0; i < 2; i++) begin
            cap[i] = mmem[widx(r_addr[i])];
            if (wren[0] && widx(w_addr[0]) == widx(r_addr[i])) cap[i] = w_data[0];
            if (wren[1] && widx(w_addr[1]) == widx(r_addr[i])) cap[i] = w_data[1];
        end
        for (int j = 0; j < NDUT; j++) begin
            if (reset) begin
                pend[j] = 1'b0;
                od[j][0] = '0;
                od[j][1] = '0;
            end else begin
                if (pend[j] && resp[j] <= ecyc - 1) pend[j] = 1'b0;
                if (data_req && !pend[j]) begin
                    pend[j] = 1'b1;
                    resp[j] = ecyc + j;
                    pd[j][0] = cap[0];
                    pd[j][1] = cap[1];
                end
                if (pend[j] && resp[j] == ecyc) begin
                    od[j][0] = pd[j][0];
                    od[j][1] = pd[j][1];
                end
            end
        end
        if (wren[0]) mmem[widx(w_addr[0])] = w_data[0];
        if (wren[1]) mmem[widx(w_addr[1])] = w_data[1];
    endtask

    task automatic check_all();
        bit exp_ready;
        bit exp_wait;
        logic [1:0] exp_st;
        for (int j = 0; j < NDUT; j++) begin
            exp_ready = pend[j] && (resp[j] == ecyc);
            exp_wait  = pend[j] && (ecyc < resp[j]);
            exp_st    = exp_wait ? 2'd1 : (exp_ready ? 2'd2 : 2'd0);
            check($sformatf("L%0d.wait@%0d", j + 1, ecyc), 32'(wait_v[j]), 32'(exp_wait));
            check($sformatf("L%0d.ready@%0d", j + 1, ecyc), 32'(ready_v[j]), 32'(exp_ready));
            check($sformatf("L%0d.state@%0d", j + 1, ecyc), 32'(st_v[j]), 32'(exp_st));
            check($sformatf("L%0d.data0@%0d", j + 1, ecyc), do_v[j][0], od[j][0]);
            check($sformatf("L%0d.data1@%0d", j + 1, ecyc), do_v[j][1], od[j][1]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        data_req = 1'b0;
        wren     = 2'b00;
        reset    = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset    = 1'b1;
        data_req = 1'b0;
        wren     = 2'b00;
        r_addr   = '0;
        w_addr   = '0;
        w_data   = '0;

        // Fill every word while in reset; reset state is checked each cycle
        for (int i = 0; i < DEPTH / 2; i++) begin
            wren      = 2'b11;
            w_addr[0] = 32'(8 * i);
            w_addr[1] = 32'(8 * i + 4);
            w_data[0] = $urandom;
            w_data[1] = $urandom;
            cycle();
        end
        idle(3);

        // Basic write then read (LATENCY=2 instance)
        wren = 2'b11;
        w_addr[0] = 32'h10; w_data[0] = 32'h11111111;
        w_addr[1] = 32'h14; w_data[1] = 32'h22222222;
        cycle();
        wren = 2'b00; data_req = 1'b1; r_addr[0] = 32'h10; r_addr[1] = 32'h14;
        cycle();
        data_req = 1'b0;
        check("basic.wait", 32'(wait_v[1]), 32'h1);
        check("basic.state_busy", 32'(st_v[1]), 32'h1);
        cycle();
        check("basic.ready", 32'(ready_v[1]), 32'h1);
        check("basic.state_resp", 32'(st_v[1]), 32'h2);
        check("basic.data0", do_v[1][0], 32'h11111111);
        check("basic.data1", do_v[1][1], 32'h22222222);
        cycle();
        check("basic.state_idle", 32'(st_v[1]), 32'h0);
        check("basic.ready_drop", 32'(ready_v[1]), 32'h0);
        check("basic.data_hold", do_v[1][0], 32'h11111111);
        idle(5);

        // Write collision with same-cycle read (LATENCY=1 instance)
        wren = 2'b11;
        w_addr[0] = 32'h20; w_data[0] = 32'hAAAA0000;
        w_addr[1] = 32'h20; w_data[1] = 32'hBBBB0000;
        data_req = 1'b1; r_addr[0] = 32'h20; r_addr[1] = 32'h20;
        cycle();
        check("collide.ready", 32'(ready_v[0]), 32'h1);
        check("collide.data0", do_v[0][0], 32'hBBBB0000);
        check("collide.data1", do_v[0][1], 32'hBBBB0000);
        idle(5);

        // Address aliasing
        wren = 2'b01; w_addr[0] = 32'h0; w_data[0] = 32'h5;
        cycle();
        wren = 2'b00; data_req = 1'b1;
        r_addr[0] = 32'(DEPTH * 4); r_addr[1] = 32'h3;
        cycle();
        check("alias.data0", do_v[0][0], 32'h5);
        check("alias.data1", do_v[0][1], 32'h5);
        idle(5);

        // Back-to-back requests
        data_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_addr[0] = 32'(8 * i);
            r_addr[1] = 32'(8 * i + 4);
            cycle();
            check($sformatf("b2b.ready%0d", i), 32'(ready_v[0]), 32'h1);
            check($sformatf("b2b.wait%0d", i), 32'(wait_v[0]), 32'h0);
        end
        idle(5);

        // Request and writes during BUSY (LATENCY=4 instance)
        wren = 2'b11;
        w_addr[0] = 32'h30; w_data[0] = 32'hCAFE0001;
        w_addr[1] = 32'h34; w_data[1] = 32'hCAFE0002;
        cycle();
        wren = 2'b00; data_req = 1'b1; r_addr[0] = 32'h30; r_addr[1] = 32'h34;
        cycle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy.wait%0d", i), 32'(wait_v[3]), 32'h1);
            r_addr[0] = 32'h34; r_addr[1] = 32'h30;
            wren = 2'b01; w_addr[0] = 32'h30; w_data[0] = 32'hDEAD0000 + 32'(i);
            cycle();
        end
        check("busy.ready", 32'(ready_v[3]), 32'h1);
        check("busy.data0", do_v[3][0], 32'hCAFE0001);
        check("busy.data1", do_v[3][1], 32'hCAFE0002);
        wren = 2'b00;
        cycle();
        check("busy.second_accept", 32'(st_v[3]), 32'h1);
        idle(6);

        // Reset while BUSY (LATENCY=3 instance)
        data_req = 1'b1; r_addr[0] = 32'h10; r_addr[1] = 32'h14;
        cycle();
        data_req = 1'b0;
        check("rst.busy", 32'(wait_v[2]), 32'h1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst.wait", 32'(wait_v[2]), 32'h0);
        check("rst.state", 32'(st_v[2]), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("rst.no_ready%0d", i), 32'(ready_v[2]), 32'h0);
        end
        data_req = 1'b1;
        cycle();
        data_req = 1'b0;
        cycle();
        cycle();
        check("rst.mem0", do_v[2][0], 32'h11111111);
        check("rst.mem1", do_v[2][1], 32'h22222222);
        idle(5);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            data_req  = $urandom_range(0, 1) == 1;
            r_addr[0] = $urandom_range(0, DEPTH * 16 - 1);
            r_addr[1] = $urandom_range(0, DEPTH * 16 - 1);
            wren      = 2'($urandom_range(0, 3));
            w_addr[0] = $urandom_range(0, DEPTH * 16 - 1);
            w_addr[1] = ($urandom_range(0, 3) == 0) ? w_addr[0]
                                                    : 32'($urandom_range(0, DEPTH * 16 - 1));
            w_data[0] = $urandom;
            w_data[1] = $urandom;
            cycle();
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
